// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time in clk cycles and reports duty in 0.1 % units.
// Optional 3-sample glitch filter after the synchronizer: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int SYS_FREQ    = 125,
  parameter int CNT_W       = 27,
  parameter int TIMEOUT_CYC = SYS_FREQ * 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [9:0]       duty,
  output logic             valid,
  output logic             no_signal,
  output logic             stuck_level
);

  localparam int DW = CNT_W + 10;
  localparam logic [CNT_W-1:0] K_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] K_TIMEOUT  = CNT_W'(TIMEOUT_CYC);
  localparam logic [DW-1:0]    K_THOUSAND = DW'(1000);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2} state_t;

  logic r_sync0, r_sync1, r_prev, r_rise, r_fall;
  logic w_level;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic r_h1, r_h2, r_filt;

  // Level moves only once three consecutive synchronized samples agree.
  assign w_level = ((r_sync1 == r_h1) && (r_h1 == r_h2)) ? r_sync1 : r_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h1   <= 1'b0;
      r_h2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_h1   <= r_sync1;
      r_h2   <= r_h1;
      r_filt <= w_level;
    end
  end
`else
  assign w_level = r_sync1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync0 <= pwm_in;
      r_sync1 <= r_sync0;
      r_prev  <= w_level;
      r_rise  <= w_level & ~r_prev;
      r_fall  <= ~w_level & r_prev;
    end
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_run, r_h_tmp, r_per_snap, r_high_snap, r_period, r_high;
  logic [DW-1:0]    r_rem, r_dsr;
  logic [9:0]       r_quo, r_duty;
  logic [3:0]       r_step;
  logic             r_busy, r_valid, r_no_sig, r_stuck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_run       <= '0;
      r_h_tmp     <= '0;
      r_per_snap  <= '0;
      r_high_snap <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_quo       <= 10'd0;
      r_duty      <= 10'd0;
      r_step      <= 4'd0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_no_sig    <= 1'b1;
      r_stuck     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Restoring divider: one quotient bit per cycle, then publish on the cycle after the last bit.
      if (r_busy) begin
        if (r_step != 4'd0) begin
          if (r_rem >= r_dsr) begin
            r_rem <= r_rem - r_dsr;
            r_quo <= {r_quo[8:0], 1'b1};
          end else begin
            r_quo <= {r_quo[8:0], 1'b0};
          end
          r_dsr  <= r_dsr >> 1;
          r_step <= r_step - 4'd1;
        end else begin
          r_busy   <= 1'b0;
          r_period <= r_per_snap;
          r_high   <= r_high_snap;
          r_duty   <= r_quo;
          r_valid  <= 1'b1;
          r_no_sig <= 1'b0;
        end
      end

      if (!enable) begin
        r_state <= S_IDLE;
        r_run   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_rise) begin
              r_state <= S_HIGH;
              r_run   <= K_ONE;
            end
          end
          S_HIGH: begin
            if (r_fall) begin
              r_h_tmp <= r_run;
              r_state <= S_LOW;
              r_run   <= r_run + K_ONE;
            end else if (r_run >= K_TIMEOUT) begin
              r_state  <= S_IDLE;
              r_no_sig <= 1'b1;
              r_stuck  <= w_level;
              r_duty   <= w_level ? 10'd1000 : 10'd0;
            end else begin
              r_run <= r_run + K_ONE;
            end
          end
          S_LOW: begin
            if (r_rise) begin
              r_state <= S_HIGH;
              r_run   <= K_ONE;
              // A period completing while the divider is still busy is dropped.
              if (!r_busy) begin
                r_per_snap  <= r_run;
                r_high_snap <= r_h_tmp;
                r_rem       <= DW'(r_h_tmp) * K_THOUSAND;
                r_dsr       <= DW'(r_run) << 9;
                r_quo       <= 10'd0;
                r_step      <= 4'd10;
                r_busy      <= 1'b1;
              end
            end else if (r_run >= K_TIMEOUT) begin
              r_state  <= S_IDLE;
              r_no_sig <= 1'b1;
              r_stuck  <= w_level;
              r_duty   <= w_level ? 10'd1000 : 10'd0;
            end else begin
              r_run <= r_run + K_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign period_cnt  = r_period;
  assign high_cnt    = r_high;
  assign duty        = r_duty;
  assign valid       = r_valid;
  assign no_signal   = r_no_sig;
  assign stuck_level = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: waveform-level reference model feeds an expectation queue.
module tb_pwm_capture;
  localparam int CNT_W = 27;
  localparam int TO    = 1000;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 15;
`endif

  logic clk = 1'b0;
  logic reset_n, enable, pwm_in;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [9:0] duty;
  logic valid, no_signal, stuck_level;

  pwm_capture #(.SYS_FREQ(125), .CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .duty(duty),
    .valid(valid), .no_signal(no_signal), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int p; int h; int d; int t; } exp_t;
  exp_t q[$];
  exp_t e;
  int n_vec = 0, n_err = 0;

  // Reference model state: time of last accepted rise, high time, last divider start
  bit en_m, have_rise, have_fall;
  int pr, hd, last_start, last_p, last_h;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit lvl);
    int t = cyc;
    exp_t x;
    if (!en_m) return;
    if (lvl) begin
      if (have_rise && have_fall) begin
        if (t - last_start >= 12) begin
          x.p = t - pr; x.h = hd; x.d = (hd * 1000) / (t - pr); x.t = t + LAT;
          q.push_back(x);
          last_start = t; last_p = x.p; last_h = x.h;
        end
      end
      pr = t; have_rise = 1'b1; have_fall = 1'b0;
    end else if (have_rise) begin
      hd = t - pr; have_fall = 1'b1;
    end
  endtask

  task automatic drive(input bit lvl, input int dur);
    if (pwm_in !== lvl) model_edge(lvl);
    pwm_in = lvl;
    repeat (dur) tick();
  endtask

  task automatic glitch(input int dur);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    model_edge(1'b1);
`endif
    pwm_in = 1'b1;
    repeat (dur) tick();
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    model_edge(1'b0);
`endif
    pwm_in = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_no_signal"}, no_signal, 1);
    chk({tag, "_stuck"}, stuck_level, 0);
  endtask

  // Hold pwm_in at lvl past the timeout measured from the last rise.
  task automatic hold_check(input bit lvl);
    int tr = pr;
    int off = LAT - 11;
    if (pwm_in !== lvl) model_edge(lvl);
    pwm_in = lvl;
    wait_until(tr + TO + off - 2);
    chk("pre_timeout_no_signal", no_signal, 0);
    wait_until(tr + TO + off + 2);
    chk("timeout_no_signal", no_signal, 1);
    chk("timeout_stuck", stuck_level, lvl);
    chk("timeout_duty", duty, lvl ? 1000 : 0);
    chk("timeout_period_hold", period_cnt, last_p);
    chk("timeout_high_hold", high_cnt, last_h);
    have_rise = 1'b0; have_fall = 1'b0;
    repeat (50) tick();
  endtask

  // Monitor: every valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid: got period %0d high %0d duty %0d, expected no report (cycle %0d)",
                 period_cnt, high_cnt, duty, cyc);
      end else begin
        e = q.pop_front();
        chk("period", period_cnt, e.p);
        chk("high", high_cnt, e.h);
        chk("duty", duty, e.d);
        chk("valid_cycle", cyc, e.t);
        chk("valid_no_signal", no_signal, 0);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; pwm_in = 1'b0;
    en_m = 1'b1; have_rise = 1'b0; have_fall = 1'b0;
    pr = 0; hd = 0; last_start = -1000; last_p = 0; last_h = 0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (5) tick();

    repeat (3) begin drive(1'b1, 250); drive(1'b0, 250); end
    repeat (3) begin drive(1'b1, 100); drive(1'b0, 300); end
    repeat (2) begin drive(1'b1, 50);  drive(1'b0, 350); end
    repeat (6) begin drive(1'b1, 3);   drive(1'b0, 5);   end

    drive(1'b1, 300); drive(1'b0, 100); glitch(2); drive(1'b0, 198);
    drive(1'b1, 300); drive(1'b0, 300);

    for (int i = 0; i < 40; i++) begin
      int p, h;
      if ($urandom_range(0, 4) == 0) p = $urandom_range(6, 11);
      else p = $urandom_range(12, 600);
      h = $urandom_range(3, p - 3);
      drive(1'b1, h); drive(1'b0, p - h);
    end

    drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 1);
    hold_check(1'b1);
    drive(1'b0, 300); drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 200);
    hold_check(1'b0);
    drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 250); drive(1'b0, 250);

    drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 6);
    enable = 1'b0; en_m = 1'b0; have_rise = 1'b0; have_fall = 1'b0;
    drive(1'b1, 194); drive(1'b0, 200); drive(1'b1, 50);
    enable = 1'b1; en_m = 1'b1;
    drive(1'b1, 50); drive(1'b0, 150); drive(1'b1, 120); drive(1'b0, 180);
    drive(1'b1, 100); drive(1'b0, 100);

    drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 8);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_divide_reset");
    q.delete();
    have_rise = 1'b0; have_fall = 1'b0; last_start = -1000; last_p = 0; last_h = 0;
    pwm_in = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    drive(1'b0, 100); drive(1'b1, 300); drive(1'b0, 300); drive(1'b1, 200); drive(1'b0, 200);

    repeat (40) tick();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart to the PWM generators: measures an incoming PWM waveform's period and high time in system-clock cycles.
- Reports duty in 0.1 % units (0–1000), the same scale the generator's duty input uses.
- Sits between an external PWM pin (servo feedback, fan tach, loopback from a generator) and control logic that needs the measured period and duty.

Parameters:
SYS_FREQ, 125, system clock in MHz (informational; used only for TIMEOUT_CYC default)
CNT_W, 27, width of period/high counters
TIMEOUT_CYC, SYS_FREQ*100000, cycles without a required edge before declaring loss of signal (100 ms); must be < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = measure; 0 = FSM forced to IDLE, outputs hold
pwm_in  input  1  asynchronous PWM input
period_cnt  output  CNT_W  last measured period, clk cycles
high_cnt  output  CNT_W  last measured high time, clk cycles
duty  output  10  floor(high_cnt*1000/period_cnt), 0.1 % units
valid  output  1  one-cycle pulse when period_cnt/high_cnt/duty update
no_signal  output  1  1 = no valid measurement / timeout
stuck_level  output  1  pwm_in level at the moment of timeout

Behaviour:
- Reset: period_cnt=0, high_cnt=0, duty=0, valid=0, no_signal=1, stuck_level=0; FSM=IDLE, divider idle.
- Input path: 2-flop synchronizer, then registered edge detect producing rise/fall pulses. Edge pulse occurs 3 cycles after a pwm_in transition.
- Counter `run`:
  - Set to 1 on a rise pulse.
  - Increments each cycle otherwise, in HIGH/LOW states.
  - For period P cycles, run==P at the next rise; for high time H, run==H at the fall.
- FSM states:
  - IDLE: wait for rise → HIGH.
  - HIGH: on fall, h_tmp<=run → LOW.
  - LOW: on rise, snapshot period=run, high=h_tmp, start divider, run<=1 → HIGH. The next period is measured back-to-back with no dead cycle.
- Timeout: in HIGH or LOW, if run reaches TIMEOUT_CYC with no expected edge:
  - FSM → IDLE.
  - no_signal<=1; stuck_level<=synced level.
  - duty<=1000 if level=1, else 0; period_cnt/high_cnt hold.
  - valid not pulsed.
  - If a rise and the timeout coincide, the rise wins.
- Divider:
  - Restoring division, 10 quotient bits, dividend high*1000 (CNT_W+10 bits), divisor period.
  - Exactly 10 cycles after start; on the following cycle period_cnt, high_cnt and duty update together, valid=1 for one cycle, no_signal<=0.
  - Start-to-valid latency: 11 cycles.
- Divider busy when a new period completes (P < 12 cycles): new snapshot discarded; in-flight result completes normally.
- high==period is impossible by construction. Result range 0..999 from measurement; 1000 only via timeout.
- enable=0:
  - FSM → IDLE, run cleared; an in-flight divide completes and pulses valid.
  - Re-enable waits for a fresh rise; the first period after enable is never reported partially.
- Reset asserted mid-measurement or mid-divide: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample stability filter follows the synchronizer; the filtered level changes only after 3 consecutive identical samples.
  - Pulses or gaps of 1–2 cycles are ignored.
  - Adds 2 cycles latency to both edges equally, so period/high counts are unchanged for clean inputs.
- Undefined: synchronizer output feeds edge detect directly; every 1-cycle pulse is measured.

Test Plan:
1. Reset then 1 kHz 50 % (P=125000, H=62500) → first valid 11 cycles after second rise: period_cnt=125000, high_cnt=62500, duty=500, no_signal=0.
2. 10 kHz 25 % (P=12500, H=3125) for 3 periods → valid once per period, duty=250 each; then switch to 12.5 % → next valid duty=125.
3. TIMEOUT_CYC=1000, PWM running then pwm_in held 1 → no_signal=1, stuck_level=1, duty=1000 at run==1000; held 0 instead → duty=0. Resumed PWM → no_signal clears at next valid.
4. P=8, H=3 (shorter than divider) → only every other period reports (discard rule); reported values period_cnt=8, high_cnt=3, duty=375.
5. Assert reset_n=0 mid-divide → outputs return to reset values same cycle, no valid after release until two rises seen.
6. With PWM_CAPTURE_GLITCH_FILTER_EN: 2-cycle high glitch inside LOW of a 1 kHz 50 % signal → no extra valid, duty=500. Without the macro → spurious short measurement reported.
